// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Purpose:
//   Sits in front of a single-port synchronous RAM (memory_module) and shares
//   its one port between two requesters, A and B. After reset the block first
//   sweeps every RAM word to zero (INIT). It then arbitrates round-robin between
//   the requesters (RUN), at most one RAM access per cycle.
//
// Handshake:
//   A request transfers on a rising edge where <x>_valid and <x>_ready are both
//   high. Ready is a same-cycle combinational grant. A requester may change or
//   drop its request while its ready is low, and its request fields are only
//   used while it holds the grant. Read data returns one cycle after the
//   transfer. <x>_resp_valid pulses for exactly that cycle and <x>_dout carries
//   the data. Responses cannot be stalled.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   a_valid       in   requester A has a request
//   a_ready       out  A's request is granted this cycle
//   a_r_w         in   A: 1 = write, 0 = read
//   a_addr        in   A address
//   a_din         in   A write data
//   a_resp_valid  out  A read data valid on a_dout this cycle
//   a_dout        out  A read data (RAM dout passed through)
//   b_*                same set of signals for requester B
//   init_done     out  high once the zero sweep has finished
//   mem_r_w       out  RAM r_w (1 = write)
//   mem_addr      out  RAM address
//   mem_din       out  RAM write data
//   mem_dout      in   RAM registered read data
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int ADDR       = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_r_w,
  input  logic [ADDR-1:0]       a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_dout,

  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_r_w,
  input  logic [ADDR-1:0]       b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_dout,

  output logic                  init_done,

  output logic                  mem_r_w,
  output logic [ADDR-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Priority pointer encoding: names the requester that wins under contention.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  state_t          state_q, state_d;
  logic [ADDR-1:0] cnt_q, cnt_d;
  logic            ptr_q, ptr_d;
  logic            a_resp_q, a_resp_d;
  logic            b_resp_q, b_resp_d;
  logic [ADDR-1:0] last_addr_q, last_addr_d;

  logic            grant_a;
  logic            grant_b;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= PTR_A;
      a_resp_q    <= 1'b0;
      b_resp_q    <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      a_resp_q    <= a_resp_d;
      b_resp_q    <= b_resp_d;
      last_addr_q <= last_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant selection. A lone requester always wins; the pointer only matters
  // when both are asking.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == RUN) begin
      grant_a = a_valid && (!b_valid || (ptr_q == PTR_A));
      grant_b = b_valid && (!a_valid || (ptr_q == PTR_B));
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    a_resp_d    = 1'b0;
    b_resp_d    = 1'b0;
    last_addr_d = last_addr_q;

    a_ready     = 1'b0;
    b_ready     = 1'b0;
    // Idle RUN cycles issue a harmless read at the previous address.
    mem_r_w     = 1'b0;
    mem_addr    = last_addr_q;
    mem_din     = '0;

    unique case (state_q)
      INIT: begin
        mem_r_w     = 1'b1;
        mem_addr    = cnt_q;
        last_addr_d = cnt_q;
        if (cnt_q == {ADDR{1'b1}}) begin
          // Last word written this cycle: one pass only, counter stays put.
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (grant_a) begin
          a_ready     = 1'b1;
          mem_r_w     = a_r_w;
          mem_addr    = a_addr;
          mem_din     = a_din;
          last_addr_d = a_addr;
          ptr_d       = PTR_B;
          a_resp_d    = !a_r_w;
        end else if (grant_b) begin
          b_ready     = 1'b1;
          mem_r_w     = b_r_w;
          mem_addr    = b_addr;
          mem_din     = b_din;
          last_addr_d = b_addr;
          ptr_d       = PTR_A;
          b_resp_d    = !b_r_w;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // RAM dout is already registered, so the response strobe lines up with it.
  assign a_resp_valid = a_resp_q;
  assign b_resp_valid = b_resp_q;
  assign a_dout       = mem_dout;
  assign b_dout       = mem_dout;
  assign init_done    = (state_q == RUN);

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Bench for memory_arbiter with a behavioural single-port RAM attached.
// A reference model (word array, priority pointer, last address) predicts
// grants and RAM port values per cycle. Read responses are queued with their
// due cycle and checked by an independent monitor.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam int ADDR  = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 2 ** ADDR;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic            a_valid, a_ready, a_r_w, a_resp_valid;
  logic [ADDR-1:0] a_addr;
  logic [DW-1:0]   a_din, a_dout;
  logic            b_valid, b_ready, b_r_w, b_resp_valid;
  logic [ADDR-1:0] b_addr;
  logic [DW-1:0]   b_din, b_dout;
  logic            init_done;
  logic            mem_r_w;
  logic [ADDR-1:0] mem_addr;
  logic [DW-1:0]   mem_din, mem_dout;

  memory_arbiter #(.ADDR(ADDR), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_r_w        (a_r_w),
    .a_addr       (a_addr),
    .a_din        (a_din),
    .a_resp_valid (a_resp_valid),
    .a_dout       (a_dout),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_r_w        (b_r_w),
    .b_addr       (b_addr),
    .b_din        (b_din),
    .b_resp_valid (b_resp_valid),
    .b_dout       (b_dout),
    .init_done    (init_done),
    .mem_r_w      (mem_r_w),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  // Single-port RAM with registered read data; contents survive reset.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_dout = '0;
  always @(posedge clk) begin
    if (mem_r_w) ram[mem_addr] <= mem_din;
    else         ram_dout      <= ram[mem_addr];
  end
  assign mem_dout = ram_dout;

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   mem_m [DEPTH];
  logic            ptr_m;        // 0: A preferred, 1: B preferred
  logic [ADDR-1:0] last_addr_m;
  // {due_cycle[31:0], is_b, data[DW-1:0]}
  logic [32+1+DW-1:0] exp_q[$];
  logic [32+1+DW-1:0] mon_e;
  logic               mon_en = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Response monitor: independent of the driver.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_resp_valid || b_resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'({a_resp_valid, b_resp_valid}), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_due_cycle", 64'(cyc), 64'(mon_e[32+1+DW-1:DW+1]));
          check1("resp_to_a", a_resp_valid, !mon_e[DW]);
          check1("resp_to_b", b_resp_valid, mon_e[DW]);
          check("resp_data", mon_e[DW] ? b_dout : a_dout, mon_e[DW-1:0]);
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][32+1+DW-1:DW+1]) <= cyc) begin
        mon_e = exp_q.pop_front();
        check("resp_missing", 64'({a_resp_valid, b_resp_valid}),
              mon_e[DW] ? 64'd1 : 64'd2);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: called at posedge+1, returns at the next posedge+1.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic av, input logic ar, input logic [ADDR-1:0] aa,
                             input logic [DW-1:0] ad,
                             input logic bv, input logic br, input logic [ADDR-1:0] ba,
                             input logic [DW-1:0] bd);
    int              win;  // -1 none, 0 A, 1 B
    logic            w_r_w;
    logic [ADDR-1:0] w_addr;
    logic [DW-1:0]   w_din;
    a_valid = av; a_r_w = ar; a_addr = aa; a_din = ad;
    b_valid = bv; b_r_w = br; b_addr = ba; b_din = bd;

    if (av && bv)  win = ptr_m ? 1 : 0;
    else if (av)   win = 0;
    else if (bv)   win = 1;
    else           win = -1;

    if (win == 0)      begin w_r_w = ar;   w_addr = aa;          w_din = ad; end
    else if (win == 1) begin w_r_w = br;   w_addr = ba;          w_din = bd; end
    else               begin w_r_w = 1'b0; w_addr = last_addr_m; w_din = '0; end

    @(negedge clk);
    check1("init_done_run", init_done, 1'b1);
    check1("a_ready", a_ready, win == 0);
    check1("b_ready", b_ready, win == 1);
    check1("mem_r_w", mem_r_w, w_r_w);
    check("mem_addr", 64'(mem_addr), 64'(w_addr));
    check("mem_din", mem_din, w_din);

    if (win >= 0) begin
      ptr_m       = (win == 0);
      last_addr_m = w_addr;
      if (w_r_w) mem_m[w_addr] = w_din;
      else       exp_q.push_back({32'(cyc + 1), (win == 1), mem_m[w_addr]});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  // Asserts reset immediately, releases it, and checks the zero sweep.
  // abort_at >= 0 re-asserts reset in the middle of the sweep once.
  task automatic reset_and_init(input int abort_at);
    int ab;
    ab     = abort_at;
    rst    = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    a_valid = 1; a_r_w = 0; a_addr = 0; a_din = {$urandom, $urandom};
    b_valid = 1; b_r_w = 0; b_addr = 1; b_din = {$urandom, $urandom};
    #1;
    check1("rst_init_done", init_done, 1'b0);
    check1("rst_a_ready", a_ready, 1'b0);
    check1("rst_b_ready", b_ready, 1'b0);
    check1("rst_a_resp", a_resp_valid, 1'b0);
    check1("rst_b_resp", b_resp_valid, 1'b0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      check1("init_r_w", mem_r_w, 1'b1);
      check("init_addr", 64'(mem_addr), 64'(k));
      check("init_din", mem_din, '0);
      check1("init_a_ready", a_ready, 1'b0);
      check1("init_b_ready", b_ready, 1'b0);
      check1("init_done_low", init_done, 1'b0);
      check1("init_no_resp", a_resp_valid || b_resp_valid, 1'b0);
      if (k == ab) begin
        rst = 1'b1;
        #1;
        check("abort_addr", 64'(mem_addr), 64'd0);
        check1("abort_done", init_done, 1'b0);
        ab = -1;
        k  = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        continue;
      end
      @(posedge clk); #1;
    end
    ptr_m       = 1'b0;
    last_addr_m = '1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    a_valid = 0; a_r_w = 0; a_addr = '0; a_din = '0;
    b_valid = 0; b_r_w = 0; b_addr = '0; b_din = '0;

    // Power-up sweep, then the first contended cycle goes to A.
    reset_and_init(-1);
    drive_cycle(1, 0, 5'd0, '0, 1, 0, 5'd1, '0);

    // A write then read of the same word.
    drive_cycle(1, 1, 5'd7, 64'hDEAD_BEEF, 0, 0, '0, '0);
    drive_cycle(1, 0, 5'd7, '0, 0, 0, '0, '0);
    idle(1);

    // Held contention on two addresses: strict alternation.
    for (int i = 0; i < 6; i++) drive_cycle(1, 0, 5'd3, '0, 1, 0, 5'd4, '0);
    idle(1);

    // Lone B writes, then a simultaneous request.
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, '0, '0, 1, 1, 5'(10 + i), 64'(100 + i));
    drive_cycle(1, 0, 5'd10, '0, 1, 0, 5'd11, '0);
    idle(1);

    // Same-cycle write/read hazard with pointer on A.
    drive_cycle(0, 0, '0, '0, 1, 1, 5'd20, 64'h1234);
    drive_cycle(1, 1, 5'd9, 64'h55, 1, 0, 5'd9, '0);
    drive_cycle(0, 0, '0, '0, 1, 0, 5'd9, '0);
    idle(2);

    // Reset in the middle of the sweep.
    reset_and_init(12);

    // Reset right after an accepted read: the response must be dropped.
    drive_cycle(1, 0, 5'd5, '0, 0, 0, '0, '0);
    reset_and_init(-1);

    // Randomised traffic over a narrow address window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    idle(2);

    // Reset after traffic: every word must read back as zero.
    reset_and_init(-1);
    for (int i = 0; i < DEPTH; i++) drive_cycle(1, 0, 5'(i), '0, 0, 0, '0, '0);
    idle(2);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one single-port synchronous RAM (memory_module).
- RAM interface: `r_w` high = write, low = read; registered `dout` valid the cycle after a read.
- After reset the block sweeps the whole RAM to zero, then shares the single port between requesters A and B with valid/ready handshakes.
- Read data is returned with a one-cycle-delayed response strobe.

Parameters:
- ADDR, 5, RAM address width; RAM depth = 2**ADDR words.
- DATA_WIDTH, 64, RAM word width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request accepted this cycle.
- a_r_w  in  1  A: 1 = write, 0 = read.
- a_addr  in  ADDR  A address.
- a_din  in  DATA_WIDTH  A write data.
- a_resp_valid  out  1  A read data valid on a_dout this cycle.
- a_dout  out  DATA_WIDTH  A read data.
- b_valid, b_ready, b_r_w, b_addr, b_din, b_resp_valid, b_dout: same as A, for requester B.
- init_done  out  1  high once the zero-sweep has completed.
- mem_r_w  out  1  to RAM `r_w`.
- mem_addr  out  ADDR  to RAM `addr`.
- mem_din  out  DATA_WIDTH  to RAM `din`.
- mem_dout  in  DATA_WIDTH  from RAM `dout`.

Behaviour:
- FSM states: INIT, RUN.
- Reset (async, any time) values:
  - state = INIT, sweep counter = 0, priority pointer = A.
  - init_done = 0, a_resp_valid = b_resp_valid = 0.
  - Any pending response is dropped.
- INIT:
  - mem_r_w = 1, mem_addr = counter, mem_din = 0.
  - a_ready = b_ready = 0.
  - Counter increments each cycle.
  - On the cycle counter = 2**ADDR-1, the write completes and the next state is RUN.
  - INIT lasts exactly 2**ADDR cycles; init_done rises on the first RUN cycle and stays high until reset.
  - No wrap-around beyond one pass.
- RUN, one RAM access per cycle at most:
  - Winner selection is combinational from the valid inputs and the pointer.
    - Only one valid: that requester wins.
    - Both valid: the requester named by the pointer wins.
  - The winner's ready = 1 in that cycle; the loser's ready = 0.
  - mem_r_w / mem_addr / mem_din = winner's r_w / addr / din.
  - A transfer occurs when valid && ready at the rising edge.
  - After each transfer the pointer is set to the non-winner, so contention alternates strictly A, B, A, B, ...
  - A lone requester is granted every cycle regardless of the pointer.
  - No valid: mem_r_w = 0 (harmless read), mem_addr holds its last value, mem_din = 0, no response generated.
- Responses:
  - An accepted read sets that requester's resp_valid = 1 for exactly the next cycle.
  - a_dout / b_dout = mem_dout combinationally; values are defined only while the respective resp_valid is high.
  - Accepted writes produce no response.
  - Back-to-back reads are supported at full rate (one response per cycle).
  - No response backpressure: requesters must sink the response.
- Hazards:
  - A's write and B's read to the same address in consecutive cycles: the read returns the new data, because the RAM write completes before the later read.
  - The same addresses requested in the same cycle: serialised by arbitration order; the second access sees the first's effect.
- Request inputs are sampled only when ready = 1. A requester may change its request while ready = 0.
- Latency:
  - Request acceptance: 0 cycles (same-cycle ready).
  - Read data: 1 cycle after acceptance.

Test Plan:
- Release rst with ADDR=5, both valids high:
  - Expect exactly 32 cycles with mem_r_w = 1, mem_addr 0..31, mem_din = 0, and no ready.
  - Expect init_done = 1 on cycle 33, followed by an A grant.
- In RUN, A writes 0xDEADBEEF to addr 7, then A reads addr 7:
  - Expect a_ready on both cycles.
  - Expect a_resp_valid exactly one cycle after the read, with a_dout = 0xDEADBEEF and b_resp_valid = 0.
- A and B hold reads of addrs 3 and 4 for 6 cycles, pointer = A after init:
  - Expect grants A, B, A, B, A, B.
  - Expect responses alternating with values 0 (post-init) from the correct addresses.
- Only B valid for 5 consecutive writes:
  - Expect b_ready = 1 every cycle.
  - A subsequent simultaneous request is granted to A (pointer = A after the B grants).
- Same cycle: A writes 0x55 to addr 9 and B reads addr 9, pointer = A:
  - Expect A granted first, then B.
  - Expect b_resp_valid with b_dout = 0x55 two cycles after the contended cycle.
- Assert rst mid-INIT (counter = 12), and again one cycle after an accepted read:
  - Expect outputs cleared immediately, with no resp_valid pulse.
  - Expect the sweep to restart at addr 0 and run the full 32 cycles.
